nibble_serializer: RTL and testbench
====================================

NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 1..65535.
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: data  input  4  parallel nibble from the upstream 4-bit register.
REQ-005 Port: load  input  1  request to capture data and start a frame.
REQ-006 Port: ready  output  1  high when a load will be accepted this cycle.
REQ-007 Port: busy  output  1  high while a frame is in progress.
REQ-008 Port: sdo  output  1  serial data out; line idles high.
REQ-009 Port: done  output  1  one-cycle pulse at frame completion.

Function
REQ-010 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-011 In IDLE: ready=1, busy=0, sdo=1.
REQ-012 A load is accepted only on a rising edge where ready=1 and load=1; data is captured into an internal shift register on that edge.
REQ-013 On accept, the FSM SHALL enter START, with sdo=0 from the next cycle.
REQ-014 START, each of the 4 DATA bits, and STOP SHALL each last exactly CLKS_PER_BIT cycles.
REQ-015 DATA SHALL shift bits out MSB first (data[3], data[2], data[1], data[0]); a 2-bit index counts 3 down to 0.
REQ-016 STOP SHALL drive sdo=1.
REQ-017 After STOP the FSM SHALL return to IDLE.
REQ-018 done=1 on the first IDLE cycle after STOP only, giving 6*CLKS_PER_BIT cycles from the accept edge to done.
REQ-019 load while busy=1 SHALL be ignored: no capture, no effect on the frame in progress, no queuing.
REQ-020 load on the same cycle as done SHALL be accepted (back-to-back frames with no extra idle bit).
REQ-021 Changes on data after the accept edge SHALL NOT affect the frame in progress.
REQ-022 ready and busy SHALL always be complementary.
REQ-023 All outputs SHALL be registered or decoded directly from state, with no combinational path from load to sdo.
REQ-024 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and then wrap.
REQ-025 With CLKS_PER_BIT=1, each bit SHALL last exactly one cycle.

Reset
REQ-026 reset=0 SHALL immediately, without waiting for clk, force: state=IDLE, sdo=1, ready=1, busy=0, done=0, counters=0, shift register=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no done pulse.
REQ-028 After reset release, the first accept SHALL be possible on the first rising edge where reset=1.

Structure
REQ-029 A shared package/header SHALL hold the state encoding (IDLE=0, START=1, DATA=2, STOP=3) and the frame-length constant FRAME_BITS=6.
REQ-030 One sub-module, bit_timer (parameter CLKS_PER_BIT, inputs clk/reset/clear, output tick), SHALL generate the end-of-bit strobe; the FSM and shift register stay in nibble_serializer.

Verification
REQ-031 CLKS_PER_BIT=4, load data=4'b1010 from IDLE:
- sdo = 0,1,0,1,0,1, each held 4 cycles;
- done pulses once, 24 cycles after the accept edge.
REQ-032 Mid-frame load: during a frame with data=4'b0011, pulse load with data=4'b1100 -> frame still sends 0,0,1,1, and only one done occurs.
REQ-033 Back-to-back: 4'b1111 then load asserted on the done cycle with 4'b0000 -> sdo 0,1,1,1,1,1 then 0,0,0,0,0,1, with no gap between frames.
REQ-034 Reset mid-frame: assert reset=0 during DATA -> sdo=1 and ready=1 before the next clk edge, and no done; a fresh load of 4'b0101 after release is sent correctly.
REQ-035 CLKS_PER_BIT=1, load 4'b1001 -> sdo 0,1,0,0,1,1 on consecutive cycles, and done 6 cycles after accept.
REQ-036 Data changed every cycle after the accept edge -> transmitted bits equal the value captured at accept.

Source files
------------

// File: rtl/nibble_serializer_pkg.sv
// Shared definitions for the nibble serializer: state encoding and frame constants.
package nibble_serializer_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int FRAME_BITS = 6;   // start + 4 data + stop
    localparam int CNT_W      = 16;  // wide enough for CLKS_PER_BIT up to 65535

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/nibble_serializer_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and strobes tick on the last count.
module bit_timer
    import nibble_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // With CLKS_PER_BIT=1 the counter sits at zero and tick is permanently high.
    assign tick = (cnt_q == LAST_CNT);

    // Next count: hold at zero while cleared, wrap after the last count of a bit.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nibble_serializer.sv
// Nibble serializer: sends a 4-bit value as start(0), data MSB first, stop(1).
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | line high, ready for a load
//   ST_START | start bit (sdo=0) for one bit period
//   ST_DATA  | shift_q[3] on sdo, four bit periods, idx_q 3 -> 0
//   ST_STOP  | stop bit (sdo=1) for one bit period, then done pulse
module nibble_serializer
    import nibble_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NIBBLE_W-1:0] data,
    input  logic                load,
    output logic                ready,
    output logic                busy,
    output logic                sdo,
    output logic                done
);

    state_t              state_q;
    state_t              state_d;
    logic [NIBBLE_W-1:0] shift_q;
    logic [NIBBLE_W-1:0] shift_d;
    logic [1:0]          idx_q;
    logic [1:0]          idx_d;
    logic                done_q;
    logic                done_d;
    logic                tick;
    logic                timer_clear;

    // Timer is held at zero in idle so the start bit gets a full period from accept.
    assign timer_clear = (state_q == ST_IDLE);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .tick  (tick)
    );

    // Next-state, datapath updates and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        ready   = 1'b0;
        busy    = 1'b1;
        sdo     = 1'b1;
        done    = done_q;

        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (load) begin
                    state_d = ST_START;
                    shift_d = data;
                    idx_d   = 2'd3;
                end
            end
            ST_START: begin
                sdo = 1'b0;
                if (tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                sdo = shift_q[NIBBLE_W-1];
                if (tick) begin
                    shift_d = {shift_q[NIBBLE_W-2:0], 1'b0};
                    if (idx_q == 2'd0) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q - 2'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_nibble_serializer.sv
// Self-checking bench for nibble_serializer at CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
module tb_nibble_serializer;

    typedef struct packed {
        logic sdo;
        logic done;
        logic busy;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] data4;
    logic       load4;
    logic       ready4, busy4, sdo4, done4;
    logic [3:0] data1;
    logic       load1;
    logic       ready1, busy1, sdo1, done1;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q4[$];
    exp_t q1[$];
    exp_t e4;
    exp_t e1;

    nibble_serializer #(.CLKS_PER_BIT(4)) dut4 (
        .clk   (clk),
        .reset (rst_n),
        .data  (data4),
        .load  (load4),
        .ready (ready4),
        .busy  (busy4),
        .sdo   (sdo4),
        .done  (done4)
    );

    nibble_serializer #(.CLKS_PER_BIT(1)) dut1 (
        .clk   (clk),
        .reset (rst_n),
        .data  (data1),
        .load  (load1),
        .ready (ready1),
        .busy  (busy1),
        .sdo   (sdo1),
        .done  (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected per-cycle outputs for one frame, starting the cycle after accept.
    function automatic void push_frame(input bit fast, input logic [3:0] d);
        int   n;
        exp_t e;
        n = fast ? 1 : 4;
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < n; k++) begin
                e.busy = 1'b1;
                e.done = 1'b0;
                if (b == 0)      e.sdo = 1'b0;
                else if (b == 5) e.sdo = 1'b1;
                else             e.sdo = d[4-b];
                if (fast) q1.push_back(e);
                else      q4.push_back(e);
            end
        end
    endfunction

    function automatic void push_idle(input bit fast, input int cnt, input bit first_done);
        exp_t e;
        for (int i = 0; i < cnt; i++) begin
            e.sdo  = 1'b1;
            e.busy = 1'b0;
            e.done = (i == 0) && first_done;
            if (fast) q1.push_back(e);
            else      q4.push_back(e);
        end
    endfunction

    // Scoreboard monitor for the CLKS_PER_BIT=4 instance.
    always @(negedge clk) begin
        if (q4.size() > 0) begin
            e4 = q4.pop_front();
            checks = checks + 4;
            if (sdo4 !== e4.sdo) begin
                errors++;
                $display("FAIL sdo4 cyc=%0d got=%b exp=%b", cyc, sdo4, e4.sdo);
            end
            if (done4 !== e4.done) begin
                errors++;
                $display("FAIL done4 cyc=%0d got=%b exp=%b", cyc, done4, e4.done);
            end
            if (busy4 !== e4.busy) begin
                errors++;
                $display("FAIL busy4 cyc=%0d got=%b exp=%b", cyc, busy4, e4.busy);
            end
            if (ready4 !== !e4.busy) begin
                errors++;
                $display("FAIL ready4 cyc=%0d got=%b exp=%b", cyc, ready4, !e4.busy);
            end
        end
    end

    // Scoreboard monitor for the CLKS_PER_BIT=1 instance.
    always @(negedge clk) begin
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            checks = checks + 4;
            if (sdo1 !== e1.sdo) begin
                errors++;
                $display("FAIL sdo1 cyc=%0d got=%b exp=%b", cyc, sdo1, e1.sdo);
            end
            if (done1 !== e1.done) begin
                errors++;
                $display("FAIL done1 cyc=%0d got=%b exp=%b", cyc, done1, e1.done);
            end
            if (busy1 !== e1.busy) begin
                errors++;
                $display("FAIL busy1 cyc=%0d got=%b exp=%b", cyc, busy1, e1.busy);
            end
            if (ready1 !== !e1.busy) begin
                errors++;
                $display("FAIL ready1 cyc=%0d got=%b exp=%b", cyc, ready1, !e1.busy);
            end
        end
    end

    task automatic test_reset();
        #3;
        checks = checks + 4;
        if (sdo4 !== 1'b1)   begin errors++; $display("FAIL reset_sdo4 got=%b exp=1", sdo4); end
        if (ready4 !== 1'b1) begin errors++; $display("FAIL reset_ready4 got=%b exp=1", ready4); end
        if (busy4 !== 1'b0)  begin errors++; $display("FAIL reset_busy4 got=%b exp=0", busy4); end
        if (done4 !== 1'b0)  begin errors++; $display("FAIL reset_done4 got=%b exp=0", done4); end
        @(negedge clk); #1;
        rst_n = 1'b1;
        push_idle(0, 2, 0);
        push_idle(1, 2, 0);
        for (int i = 0; i < 10 && (q4.size() != 0 || q1.size() != 0); i++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (q4.size() != 0 || q1.size() != 0) begin
            errors++; $display("FAIL reset_idle_timeout left=%0d", q4.size() + q1.size());
        end
    endtask

    task automatic test_basic();
        @(negedge clk); #1;
        data4 = 4'b1010; load4 = 1'b1;
        push_frame(0, 4'b1010);
        push_idle(0, 3, 1);
        @(negedge clk); #1;
        load4 = 1'b0;
        for (int i = 0; i < 100 && q4.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (q4.size() != 0) begin errors++; $display("FAIL basic_timeout left=%0d exp=0", q4.size()); end
    endtask

    task automatic test_mid_frame_load();
        @(negedge clk); #1;
        data4 = 4'b0011; load4 = 1'b1;
        push_frame(0, 4'b0011);
        push_idle(0, 4, 1);
        for (int c = 1; c < 100 && q4.size() != 0; c++) begin
            @(negedge clk); #1;
            load4 = (c == 9);
            if (c == 9) data4 = 4'b1100;
        end
        load4 = 1'b0;
        checks++;
        if (q4.size() != 0) begin errors++; $display("FAIL midload_timeout left=%0d exp=0", q4.size()); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); #1;
        data4 = 4'b1111; load4 = 1'b1;
        push_frame(0, 4'b1111);
        push_idle(0, 1, 1);
        push_frame(0, 4'b0000);
        push_idle(0, 3, 1);
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk); #1;
            load4 = 1'b0;
            if (c == 25) begin
                load4 = 1'b1; data4 = 4'b0000;
            end
        end
        @(negedge clk); #1;
        load4 = 1'b0;
        for (int i = 0; i < 100 && q4.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (q4.size() != 0) begin errors++; $display("FAIL b2b_timeout left=%0d exp=0", q4.size()); end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk); #1;
        data4 = 4'b0011; load4 = 1'b1;
        push_frame(0, 4'b0011);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); #1;
            load4 = 1'b0;
        end
        q4.delete();
        #1 rst_n = 1'b0;
        #1;
        checks = checks + 4;
        if (sdo4 !== 1'b1)   begin errors++; $display("FAIL rstmid_sdo got=%b exp=1", sdo4); end
        if (ready4 !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", ready4); end
        if (busy4 !== 1'b0)  begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy4); end
        if (done4 !== 1'b0)  begin errors++; $display("FAIL rstmid_done got=%b exp=0", done4); end
        @(posedge clk); #1;
        checks++;
        if (done4 !== 1'b0 || sdo4 !== 1'b1) begin
            errors++; $display("FAIL rstmid_hold done=%b sdo=%b exp done=0 sdo=1", done4, sdo4);
        end
        @(negedge clk); #1;
        rst_n = 1'b1;
        data4 = 4'b0101; load4 = 1'b1;
        push_frame(0, 4'b0101);
        push_idle(0, 3, 1);
        @(negedge clk); #1;
        load4 = 1'b0;
        for (int i = 0; i < 100 && q4.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (q4.size() != 0) begin errors++; $display("FAIL rstmid_timeout left=%0d exp=0", q4.size()); end
    endtask

    task automatic test_data_change();
        @(negedge clk); #1;
        data4 = 4'b0110; load4 = 1'b1;
        push_frame(0, 4'b0110);
        push_idle(0, 2, 1);
        for (int i = 0; i < 100 && q4.size() != 0; i++) begin
            @(negedge clk); #1;
            load4 = 1'b0;
            data4 = 4'($urandom);
        end
        checks++;
        if (q4.size() != 0) begin errors++; $display("FAIL datachg_timeout left=%0d exp=0", q4.size()); end
    endtask

    task automatic test_fast_bit();
        @(negedge clk); #1;
        data1 = 4'b1001; load1 = 1'b1;
        push_frame(1, 4'b1001);
        push_idle(1, 1, 1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk); #1;
            load1 = (c == 7);
            if (c == 3) data1 = 4'b0110;
            if (c == 7) data1 = 4'b0111;
        end
        push_frame(1, 4'b0111);
        push_idle(1, 3, 1);
        @(negedge clk); #1;
        load1 = 1'b0;
        for (int i = 0; i < 50 && q1.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (q1.size() != 0) begin errors++; $display("FAIL fast_timeout left=%0d exp=0", q1.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        data4 = 4'b0000; load4 = 1'b0;
        data1 = 4'b0000; load1 = 1'b0;
        test_reset();
        test_basic();
        test_mid_frame_load();
        test_back_to_back();
        test_reset_mid_frame();
        test_data_change();
        test_fast_bit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
